clock_mode_ctrl: RTL and testbench
==================================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick (100 MHz clk).
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, ms a raw button must be stable before its debounced level changes.
REQ-003 SHALL have parameter REPEAT_DELAY_MS, default 500, hold time before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_RATE_MS, default 200, auto-repeat period.
REQ-005 SHALL have parameter TIMEOUT_MS, default 10000, idle time after which a set mode exits.
REQ-006 SHALL have parameter BLINK_MS, default 500, half-period of the set-mode blink.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports btn_mode, btn_up, btn_down, btn_sw_run, btn_sw_zero, each input, 1, raw asynchronous button, active-high.
REQ-010 SHALL have port mode, output, 2, 0=CLOCK 1=SET_HOUR 2=SET_MIN 3=STOPWATCH.
REQ-011 SHALL have ports hour_inc, hour_dec, min_inc, min_dec, each output, 1, single-cycle adjust strobe to the timekeeping datapath.
REQ-012 SHALL have port sec_clear, output, 1, single-cycle strobe that zeroes seconds.
REQ-013 SHALL have port sw_run, output, 1, stopwatch run level.
REQ-014 SHALL have port sw_clear, output, 1, single-cycle stopwatch zero strobe.
REQ-015 SHALL have ports blank_hour and blank_min, each output, 1, display blanking for the digits being set.

Function
REQ-016 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-017 SHALL generate ms_tick as a 1-cycle pulse every TICK_DIV cycles from a free-running prescaler (0..TICK_DIV-1).
REQ-018 SHALL change a debounced level only on ms_tick, once the synchronized input has differed from it on DEBOUNCE_MS consecutive ticks; any bounce resets that count to 0.
REQ-019 SHALL use only debounced rising edges ("press") and levels ("held") below this point.
REQ-020 SHALL drive every strobe exactly 1 cycle high, registered, in the cycle after the debounced edge or repeat event.
REQ-021 SHALL advance mode cyclically CLOCK->SET_HOUR->SET_MIN->STOPWATCH->CLOCK, one step per btn_mode press.
REQ-022 SHALL, in SET_HOUR, map an up press to hour_inc and a down press to hour_dec; in SET_MIN, to min_inc and min_dec respectively.
REQ-023 SHALL ignore up/down in CLOCK and STOPWATCH modes.
REQ-024 SHALL, when up or down is held alone in a set mode, issue a further strobe at REPEAT_DELAY_MS after the press, then one every REPEAT_RATE_MS until release.
REQ-025 SHALL emit no strobe and clear the repeat counter while up and down are both held; releasing one leaves the other held without a fresh press, so no strobes follow.
REQ-026 SHALL emit no strobe for up/down when a btn_mode press occurs in the same cycle; the mode change wins, and the repeat counter clears on every mode change.
REQ-027 SHALL pulse sec_clear on leaving SET_MIN (by btn_mode or timeout) if at least one min_inc/min_dec was issued during that visit, otherwise not.
REQ-028 SHALL return mode to CLOCK from SET_HOUR or SET_MIN after TIMEOUT_MS consecutive ms with no button held; any held button restarts the count.
REQ-029 SHALL never time out of STOPWATCH.
REQ-030 SHALL toggle sw_run on each btn_sw_run press, only in STOPWATCH mode; sw_run holds its value in all other modes.
REQ-031 SHALL pulse sw_clear on a btn_sw_zero press in STOPWATCH mode only when sw_run=0; when running, the press is ignored.
REQ-032 SHALL toggle blink_phase every BLINK_MS ms in set modes, forcing it to 0 on mode entry, on any strobe and while up/down is held.
REQ-033 SHALL drive blank_hour = (mode==SET_HOUR)&blink_phase and blank_min = (mode==SET_MIN)&blink_phase, both 0 in other modes.
REQ-034 SHALL size all counters to hold their parameter value without overflow.

Reset
REQ-035 SHALL, on reset asserted, immediately clear mode to CLOCK, all strobes, sw_run, blank_hour/blank_min, the prescaler, the debounce, repeat, timeout and blink counters, and the debounced levels to 0.
REQ-036 SHALL abort any in-progress repeat or timeout when reset is asserted mid-operation; no strobe may follow release of reset.
REQ-037 SHALL treat a button held across reset release as a new press after DEBOUNCE_MS.

Verification (TICK_DIV=10, DEBOUNCE_MS=2, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, TIMEOUT_MS=20, BLINK_MS=5)
REQ-038 SHALL cover: btn_mode pressed 4 times, each with 3 ms of bounce -> mode 1,2,3,0, exactly one step per press.
REQ-039 SHALL cover: in SET_HOUR, btn_up held 10 ms -> hour_inc pulses at press, +5 ms, +7 ms, +9 ms (4 total), each 1 cycle.
REQ-040 SHALL cover: in SET_MIN, one min_dec followed by a btn_mode press -> sec_clear 1 cycle and mode=3; a repeat visit with no adjust gives no sec_clear.
REQ-041 SHALL cover: in SET_HOUR, idle 20 ms -> mode=0; a press at 19 ms restarts the count.
REQ-042 SHALL cover: in STOPWATCH, run press then zero press -> sw_run=1 with no sw_clear; second run press then zero press -> sw_run=0 and sw_clear 1 cycle.
REQ-043 SHALL cover: reset asserted during an auto-repeat hold -> all outputs 0 asynchronously, and after release exactly one strobe-free press is detected, advancing nothing in CLOCK mode.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Button front end (2-flop sync + ms-tick debounce) and mode/adjust controller
// for a clock with hour/minute set modes, auto-repeat, idle timeout and stopwatch.
module clock_mode_ctrl #(
    parameter int TICK_DIV        = 100000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 200,
    parameter int TIMEOUT_MS      = 10000,
    parameter int BLINK_MS        = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sw_run,
    input  logic       btn_sw_zero,
    output logic [1:0] mode,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic       sec_clear,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       blank_hour,
    output logic       blank_min
);
    typedef enum logic [1:0] {
        M_CLOCK     = 2'd0,
        M_SET_HOUR  = 2'd1,
        M_SET_MIN   = 2'd2,
        M_STOPWATCH = 2'd3
    } mode_t;

    localparam int NB     = 5;
    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DN   = 2;
    localparam int B_RUN  = 3;
    localparam int B_ZERO = 4;
    localparam int RMAX   = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int PW     = $clog2(TICK_DIV + 1);
    localparam int DW     = $clog2(DEBOUNCE_MS + 1);
    localparam int RW     = $clog2(RMAX + 1);
    localparam int TW     = $clog2(TIMEOUT_MS + 1);
    localparam int BW     = $clog2(BLINK_MS + 1);

    logic [NB-1:0] raw, sync1_q, sync2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          ms_tick;
    logic [NB-1:0] db_q, db_d, rise;
    logic [DW-1:0] db_cnt_q [NB];
    logic [DW-1:0] db_cnt_d [NB];

    assign raw     = {btn_sw_zero, btn_sw_run, btn_down, btn_up, btn_mode};
    assign ms_tick = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = ms_tick ? '0 : presc_q + PW'(1);

    // A level flips only after DEBOUNCE_MS consecutive ticks of disagreement.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NB; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (ms_tick) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign rise = db_d & ~db_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            presc_q  <= presc_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    mode_t         mode_q, mode_d;
    logic [RW-1:0] rpt_q, rpt_d, rpt_lim;
    logic          rpt_en_q, rpt_en_d, rpt_first_q, rpt_first_d;
    logic [TW-1:0] to_q, to_d;
    logic [BW-1:0] bl_q, bl_d;
    logic          phase_q, phase_d, min_adj_q, min_adj_d, sw_run_q, sw_run_d;
    logic          hour_inc_q, hour_dec_q, min_inc_q, min_dec_q, sec_clear_q, sw_clear_q;
    logic          hour_inc_d, hour_dec_d, min_inc_d, min_dec_d, sec_clear_d, sw_clear_d;
    logic          set_mode, up_evt, dn_evt;

    assign set_mode = (mode_q == M_SET_HOUR) || (mode_q == M_SET_MIN);
    assign rpt_lim  = rpt_first_q ? RW'(REPEAT_DELAY_MS - 1) : RW'(REPEAT_RATE_MS - 1);

    always_comb begin
        mode_d      = mode_q;
        rpt_d       = rpt_q;
        rpt_en_d    = rpt_en_q;
        rpt_first_d = rpt_first_q;
        to_d        = to_q;
        bl_d        = bl_q;
        phase_d     = phase_q;
        min_adj_d   = min_adj_q;
        sw_run_d    = sw_run_q;
        hour_inc_d  = 1'b0;
        hour_dec_d  = 1'b0;
        min_inc_d   = 1'b0;
        min_dec_d   = 1'b0;
        sec_clear_d = 1'b0;
        sw_clear_d  = 1'b0;
        up_evt      = 1'b0;
        dn_evt      = 1'b0;

        if (rise[B_MODE]) begin
            mode_d      = mode_t'(mode_q + 2'd1);
            rpt_d       = '0;
            rpt_en_d    = 1'b0;
            to_d        = '0;
            bl_d        = '0;
            phase_d     = 1'b0;
            sec_clear_d = (mode_q == M_SET_MIN) && min_adj_q;
            min_adj_d   = 1'b0;
        end else if (set_mode) begin
            if (db_d[B_UP] && db_d[B_DN]) begin
                rpt_d    = '0;
                rpt_en_d = 1'b0;
            end else if (rise[B_UP] || rise[B_DN]) begin
                up_evt      = rise[B_UP];
                dn_evt      = rise[B_DN];
                rpt_d       = '0;
                rpt_en_d    = 1'b1;
                rpt_first_d = 1'b1;
            end else if (!(db_d[B_UP] || db_d[B_DN])) begin
                rpt_d    = '0;
                rpt_en_d = 1'b0;
            end else if (rpt_en_q && ms_tick) begin
                if (rpt_q == rpt_lim) begin
                    up_evt      = db_d[B_UP];
                    dn_evt      = db_d[B_DN];
                    rpt_d       = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_d = rpt_q + RW'(1);
                end
            end

            hour_inc_d = up_evt && (mode_q == M_SET_HOUR);
            hour_dec_d = dn_evt && (mode_q == M_SET_HOUR);
            min_inc_d  = up_evt && (mode_q == M_SET_MIN);
            min_dec_d  = dn_evt && (mode_q == M_SET_MIN);
            if ((up_evt || dn_evt) && (mode_q == M_SET_MIN)) min_adj_d = 1'b1;

            if (db_d[B_UP] || db_d[B_DN] || up_evt || dn_evt) begin
                bl_d    = '0;
                phase_d = 1'b0;
            end else if (ms_tick) begin
                if (bl_q == BW'(BLINK_MS - 1)) begin
                    bl_d    = '0;
                    phase_d = ~phase_q;
                end else begin
                    bl_d = bl_q + BW'(1);
                end
            end

            // Idle timeout: any held button (including stopwatch keys) restarts it.
            if (|db_d) begin
                to_d = '0;
            end else if (ms_tick) begin
                if (to_q == TW'(TIMEOUT_MS - 1)) begin
                    mode_d      = M_CLOCK;
                    to_d        = '0;
                    rpt_d       = '0;
                    rpt_en_d    = 1'b0;
                    bl_d        = '0;
                    phase_d     = 1'b0;
                    sec_clear_d = (mode_q == M_SET_MIN) && min_adj_q;
                    min_adj_d   = 1'b0;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
        end else begin
            rpt_d    = '0;
            rpt_en_d = 1'b0;
            to_d     = '0;
            bl_d     = '0;
            phase_d  = 1'b0;
        end

        if (mode_q == M_STOPWATCH) begin
            if (rise[B_RUN]) sw_run_d = ~sw_run_q;
            sw_clear_d = rise[B_ZERO] && !sw_run_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= M_CLOCK;
            rpt_q       <= '0;
            rpt_en_q    <= 1'b0;
            rpt_first_q <= 1'b0;
            to_q        <= '0;
            bl_q        <= '0;
            phase_q     <= 1'b0;
            min_adj_q   <= 1'b0;
            sw_run_q    <= 1'b0;
            hour_inc_q  <= 1'b0;
            hour_dec_q  <= 1'b0;
            min_inc_q   <= 1'b0;
            min_dec_q   <= 1'b0;
            sec_clear_q <= 1'b0;
            sw_clear_q  <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            rpt_q       <= rpt_d;
            rpt_en_q    <= rpt_en_d;
            rpt_first_q <= rpt_first_d;
            to_q        <= to_d;
            bl_q        <= bl_d;
            phase_q     <= phase_d;
            min_adj_q   <= min_adj_d;
            sw_run_q    <= sw_run_d;
            hour_inc_q  <= hour_inc_d;
            hour_dec_q  <= hour_dec_d;
            min_inc_q   <= min_inc_d;
            min_dec_q   <= min_dec_d;
            sec_clear_q <= sec_clear_d;
            sw_clear_q  <= sw_clear_d;
        end
    end

    assign mode       = mode_q;
    assign hour_inc   = hour_inc_q;
    assign hour_dec   = hour_dec_q;
    assign min_inc    = min_inc_q;
    assign min_dec    = min_dec_q;
    assign sec_clear  = sec_clear_q;
    assign sw_run     = sw_run_q;
    assign sw_clear   = sw_clear_q;
    assign blank_hour = (mode_q == M_SET_HOUR) && phase_q;
    assign blank_min  = (mode_q == M_SET_MIN) && phase_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with a 10-cycle ms tick and short timing parameters.
module tb_clock_mode_ctrl;
    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DN   = 2;
    localparam int B_RUN  = 3;
    localparam int B_ZERO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic [1:0] mode;
    logic       hour_inc, hour_dec, min_inc, min_dec, sec_clear, sw_run, sw_clear;
    logic       blank_hour, blank_min;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hour_inc_n = 0, hour_dec_n = 0, min_inc_n = 0, min_dec_n = 0;
    int sec_clear_n = 0, sw_clear_n = 0;
    int mode_chg_cyc = 0;
    logic [1:0] mode_prev = 2'd0;
    int hi_stamps[$];

    clock_mode_ctrl #(
        .TICK_DIV(10), .DEBOUNCE_MS(2), .REPEAT_DELAY_MS(5),
        .REPEAT_RATE_MS(2), .TIMEOUT_MS(20), .BLINK_MS(5)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn[B_MODE]), .btn_up(btn[B_UP]), .btn_down(btn[B_DN]),
        .btn_sw_run(btn[B_RUN]), .btn_sw_zero(btn[B_ZERO]),
        .mode(mode), .hour_inc(hour_inc), .hour_dec(hour_dec),
        .min_inc(min_inc), .min_dec(min_dec), .sec_clear(sec_clear),
        .sw_run(sw_run), .sw_clear(sw_clear),
        .blank_hour(blank_hour), .blank_min(blank_min)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe/mode monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (hour_inc) begin
            hour_inc_n <= hour_inc_n + 1;
            hi_stamps.push_back(cyc);
        end
        if (hour_dec)  hour_dec_n  <= hour_dec_n + 1;
        if (min_inc)   min_inc_n   <= min_inc_n + 1;
        if (min_dec)   min_dec_n   <= min_dec_n + 1;
        if (sec_clear) sec_clear_n <= sec_clear_n + 1;
        if (sw_clear)  sw_clear_n  <= sw_clear_n + 1;
        if (mode != mode_prev) begin
            mode_chg_cyc <= cyc;
            mode_prev    <= mode;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int all_strobes();
        return hour_inc_n + hour_dec_n + min_inc_n + min_dec_n + sec_clear_n + sw_clear_n;
    endfunction

    function automatic int stamp(input int i);
        if (i < hi_stamps.size()) return hi_stamps[i];
        return -1000;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Toggle every 2 cycles for 3 ms: tick samples alternate, so no level change.
    task automatic bounce_to(input int idx, input logic lvl);
        for (int k = 0; k < 15; k++) begin
            btn[idx] = ~btn[idx];
            wait_cyc(2);
        end
        btn[idx] = lvl;
    endtask

    task automatic press_step(input int idx);
        bounce_to(idx, 1'b1);
        wait_cyc(50);
        bounce_to(idx, 1'b0);
        wait_cyc(50);
    endtask

    task automatic hold_clean(input int idx, input int n);
        btn[idx] = 1'b1;
        wait_cyc(n);
        btn[idx] = 1'b0;
    endtask

    int s0, q0, m;

    initial begin
        reset = 1'b0;
        btn   = '0;
        #2 reset = 1'b1;
        wait_cyc(3);
        check("rst_mode", mode, 0);
        check("rst_strobes", {hour_inc, hour_dec, min_inc, min_dec, sec_clear, sw_clear}, 0);
        check("rst_sw_run", sw_run, 0);
        check("rst_blank", {blank_hour, blank_min}, 0);
        reset = 1'b0;
        wait_cyc(5);

        // Mode stepping with bounce, one step per press.
        for (int k = 1; k <= 4; k++) begin
            bounce_to(B_MODE, 1'b1);
            wait_cyc(50);
            check($sformatf("mode_press_%0d", k), mode, k % 4);
            bounce_to(B_MODE, 1'b0);
            wait_cyc(50);
            check($sformatf("mode_release_%0d", k), mode, k % 4);
        end
        check("no_strobe_mode_walk", all_strobes(), 0);

        // Auto-repeat in SET_HOUR: press, +5, +7, +9 ms.
        press_step(B_MODE);
        check("enter_set_hour", mode, 1);
        q0 = hi_stamps.size();
        s0 = hour_dec_n + min_inc_n + min_dec_n;
        hold_clean(B_UP, 100);
        wait_cyc(100);
        check("rpt_count", hi_stamps.size() - q0, 4);
        check("rpt_gap_delay", stamp(q0 + 1) - stamp(q0), 50);
        check("rpt_gap_rate1", stamp(q0 + 2) - stamp(q0 + 1), 20);
        check("rpt_gap_rate2", stamp(q0 + 3) - stamp(q0 + 2), 20);
        check("rpt_other_strobes", hour_dec_n + min_inc_n + min_dec_n - s0, 0);

        // Up and down together: only the initial up press strobes.
        s0 = hour_inc_n + hour_dec_n;
        btn[B_UP] = 1'b1;
        wait_cyc(40);
        btn[B_DN] = 1'b1;
        wait_cyc(40);
        btn[B_DN] = 1'b0;
        wait_cyc(100);
        btn[B_UP] = 1'b0;
        wait_cyc(50);
        check("both_held_strobes", hour_inc_n + hour_dec_n - s0, 1);

        for (int k = 0; k < 400 && mode != 2'd0; k++) @(negedge clk);
        check("idle_timeout_reached", mode, 0);

        // Precise timeout: mode key held 3 ms, then 20 idle ms.
        hold_clean(B_MODE, 30);
        m = mode_chg_cyc;
        check("to_enter", mode, 1);
        wait_until(m + 70);
        check("blink_on", blank_hour, 1);
        check("blink_min_off", blank_min, 0);
        wait_until(m + 120);
        check("blink_off", blank_hour, 0);
        wait_until(m + 210);
        check("to_before", mode, 1);
        wait_until(m + 230);
        check("to_after", mode, 0);

        // A held button at 19 ms idle restarts the count.
        hold_clean(B_MODE, 30);
        m = mode_chg_cyc;
        wait_until(m + 190);
        btn[B_RUN] = 1'b1;
        wait_until(m + 220);
        btn[B_RUN] = 1'b0;
        wait_until(m + 230);
        check("restart_no_to", mode, 1);
        wait_until(m + 420);
        check("restart_before", mode, 1);
        wait_until(m + 440);
        check("restart_after", mode, 0);
        check("run_ignored_in_set", sw_run, 0);

        // sec_clear only after a minute adjust in SET_MIN.
        s0 = sec_clear_n;
        press_step(B_MODE);
        press_step(B_MODE);
        check("enter_set_min", mode, 2);
        q0 = min_dec_n;
        hold_clean(B_DN, 30);
        wait_cyc(50);
        check("min_dec_once", min_dec_n - q0, 1);
        press_step(B_MODE);
        check("leave_min_mode", mode, 3);
        check("sec_clear_once", sec_clear_n - s0, 1);
        s0 = sec_clear_n;
        for (int k = 0; k < 4; k++) press_step(B_MODE);
        check("revisit_mode", mode, 3);
        check("sec_clear_none", sec_clear_n - s0, 0);

        // Stopwatch run/zero.
        s0 = sw_clear_n;
        press_step(B_RUN);
        check("sw_run_on", sw_run, 1);
        press_step(B_ZERO);
        check("zero_while_running", sw_clear_n - s0, 0);
        press_step(B_MODE);
        check("sw_leave", mode, 0);
        check("sw_run_held", sw_run, 1);
        press_step(B_RUN);
        check("run_ignored_clock", sw_run, 1);
        for (int k = 0; k < 3; k++) press_step(B_MODE);
        check("sw_back", mode, 3);
        press_step(B_RUN);
        check("sw_run_off", sw_run, 0);
        press_step(B_ZERO);
        check("zero_stopped", sw_clear_n - s0, 1);
        press_step(B_MODE);
        check("clock_again", mode, 0);
        s0 = all_strobes();
        press_step(B_UP);
        press_step(B_DN);
        check("updown_ignored_clock", all_strobes() - s0, 0);

        // Reset during auto-repeat.
        press_step(B_MODE);
        check("pre_reset_mode", mode, 1);
        q0 = hour_inc_n;
        btn[B_UP] = 1'b1;
        wait_cyc(90);
        check("pre_reset_repeat", hour_inc_n - q0, 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_mode", mode, 0);
        check("async_rst_strobes", {hour_inc, hour_dec, min_inc, min_dec, sec_clear, sw_clear}, 0);
        check("async_rst_misc", {sw_run, blank_hour, blank_min}, 0);
        wait_cyc(20);
        reset = 1'b0;
        s0 = all_strobes();
        wait_cyc(100);
        check("post_rst_mode", mode, 0);
        check("post_rst_strobes", all_strobes() - s0, 0);
        btn[B_UP] = 1'b0;
        wait_cyc(60);
        check("post_rel_mode", mode, 0);
        check("post_rel_strobes", all_strobes() - s0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
